// File: rtl/fp_misc_pkg.sv
// Shared types for the FP misc unit: op encoding, class bits, canonical NaN.
// Imported by fp_classify and fp_misc_unit.
package fp_misc_pkg;

  typedef enum logic [3:0] {
    OP_SGNJ  = 4'd0,
    OP_SGNJN = 4'd1,
    OP_SGNJX = 4'd2,
    OP_MIN   = 4'd3,
    OP_MAX   = 4'd4,
    OP_FEQ   = 4'd5,
    OP_FLT   = 4'd6,
    OP_FLE   = 4'd7,
    OP_CLASS = 4'd8,
    OP_MV_X  = 4'd9
  } fp_misc_op_t;

  localparam int CLS_WIDTH    = 10;
  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  typedef struct packed {
    logic                 sign;
    logic                 is_zero;
    logic                 is_sub;
    logic                 is_inf;
    logic                 is_snan;
    logic                 is_qnan;
    logic [CLS_WIDTH-1:0] cls;
  } fp_class_t;

  // Sign 0, exponent all ones, quiet bit set; caller keeps the low FLEN bits.
  function automatic logic [63:0] canon_nan(
    input int unsigned ew,
    input int unsigned mw
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= int'(mw) && i < int'(mw + ew)) r[i] = 1'b1;
    end
    r[mw-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier (any EXP/MANT width).
// In: val. Out: sign, is_zero/sub/inf/snan/qnan, 10-bit one-hot cls.
module fp_classify
  import fp_misc_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  localparam int FLEN = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic [FLEN-1:0]      val,
  output logic                 sign,
  output logic                 is_zero,
  output logic                 is_sub,
  output logic                 is_inf,
  output logic                 is_snan,
  output logic                 is_qnan,
  output logic [CLS_WIDTH-1:0] cls
);

  logic [EXP_WIDTH-1:0]  ex;
  logic [MANT_WIDTH-1:0] mant;
  logic ex_ones, ex_zero, man_zero;
  logic is_nan, is_norm;

  assign sign     = val[FLEN-1];
  assign ex       = val[FLEN-2:MANT_WIDTH];
  assign mant     = val[MANT_WIDTH-1:0];
  assign ex_ones  = &ex;
  assign ex_zero  = ~|ex;
  assign man_zero = ~|mant;

  assign is_zero = ex_zero & man_zero;
  assign is_sub  = ex_zero & ~man_zero;
  assign is_inf  = ex_ones & man_zero;
  assign is_nan  = ex_ones & ~man_zero;
  assign is_norm = ~ex_zero & ~ex_ones;
  assign is_snan = is_nan & ~mant[MANT_WIDTH-1];
  assign is_qnan = is_nan & mant[MANT_WIDTH-1];

  always_comb begin
    cls = '0;
    cls[CLS_NEG_INF]  = sign & is_inf;
    cls[CLS_NEG_NORM] = sign & is_norm;
    cls[CLS_NEG_SUB]  = sign & is_sub;
    cls[CLS_NEG_ZERO] = sign & is_zero;
    cls[CLS_POS_ZERO] = ~sign & is_zero;
    cls[CLS_POS_SUB]  = ~sign & is_sub;
    cls[CLS_POS_NORM] = ~sign & is_norm;
    cls[CLS_POS_INF]  = ~sign & is_inf;
    cls[CLS_SNAN]     = is_snan;
    cls[CLS_QNAN]     = is_qnan;
  end

endmodule

// File: rtl/fp_misc_unit.sv
// Two-stage FP sign-inject/min/max/compare/classify/move unit, valid/ready.
// Ports: in_* request, out_* result (fp or int), fflags_nv sticky + clear.
module fp_misc_unit
  import fp_misc_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int XLEN       = 32,
  parameter int ID_WIDTH   = 5,
  localparam int FLEN = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [FLEN-1:0]     in_a,
  input  logic [FLEN-1:0]     in_b,
  input  logic [ID_WIDTH-1:0] in_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FLEN-1:0]     out_fp,
  output logic [XLEN-1:0]     out_int,
  output logic                out_to_int,
  output logic                out_nv,
  output logic [ID_WIDTH-1:0] out_id,
  output logic                fflags_nv,
  input  logic                fflags_nv_clear
);

  localparam logic [63:0] CANON64 =
    canon_nan(EXP_WIDTH, MANT_WIDTH);
  localparam logic [FLEN-1:0] CANON =
    CANON64[FLEN-1:0];

  typedef struct packed {
    logic [3:0]          op;
    logic [FLEN-1:0]     a;
    logic [FLEN-1:0]     b;
    logic [ID_WIDTH-1:0] id;
    fp_class_t           ca;
    fp_class_t           cb;
  } s1_t;

  fp_class_t cls_a, cls_b;
  s1_t       s1_q;
  logic      s1_valid;
  logic      s2_free;

  fp_classify #(
    .EXP_WIDTH (EXP_WIDTH),
    .MANT_WIDTH(MANT_WIDTH)
  ) u_cls_a (
    .val    (in_a),
    .sign   (cls_a.sign),
    .is_zero(cls_a.is_zero),
    .is_sub (cls_a.is_sub),
    .is_inf (cls_a.is_inf),
    .is_snan(cls_a.is_snan),
    .is_qnan(cls_a.is_qnan),
    .cls    (cls_a.cls)
  );

  fp_classify #(
    .EXP_WIDTH (EXP_WIDTH),
    .MANT_WIDTH(MANT_WIDTH)
  ) u_cls_b (
    .val    (in_b),
    .sign   (cls_b.sign),
    .is_zero(cls_b.is_zero),
    .is_sub (cls_b.is_sub),
    .is_inf (cls_b.is_inf),
    .is_snan(cls_b.is_snan),
    .is_qnan(cls_b.is_qnan),
    .cls    (cls_b.cls)
  );

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.op <= in_op;
        s1_q.a  <= in_a;
        s1_q.b  <= in_b;
        s1_q.id <= in_id;
        s1_q.ca <= cls_a;
        s1_q.cb <= cls_b;
      end
    end
  end

  logic [FLEN-2:0] a_mag, b_mag;
  logic a_s, b_s;
  logic a_nan, b_nan, any_nan, any_snan;
  logic both_zero, same, ord_lt;
  logic [XLEN-1:0] mvx;

  assign a_s       = s1_q.a[FLEN-1];
  assign b_s       = s1_q.b[FLEN-1];
  assign a_mag     = s1_q.a[FLEN-2:0];
  assign b_mag     = s1_q.b[FLEN-2:0];
  assign a_nan     = s1_q.ca.is_snan | s1_q.ca.is_qnan;
  assign b_nan     = s1_q.cb.is_snan | s1_q.cb.is_qnan;
  assign any_nan   = a_nan | b_nan;
  assign any_snan  = s1_q.ca.is_snan | s1_q.cb.is_snan;
  assign both_zero = s1_q.ca.is_zero & s1_q.cb.is_zero;
  assign same      = s1_q.a == s1_q.b;

  // Total order on non-NaN values with -0 below +0; FLT/FLE mask
  // the zero pair separately, MIN/MAX rely on it.
  always_comb begin
    ord_lt = 1'b0;
    if (a_s != b_s) ord_lt = a_s;
    else if (a_s)   ord_lt = b_mag < a_mag;
    else            ord_lt = a_mag < b_mag;
  end

  if (FLEN >= XLEN) begin : g_mv_trunc
    assign mvx = s1_q.a[XLEN-1:0];
  end else begin : g_mv_sext
    assign mvx = {{(XLEN-FLEN){s1_q.a[FLEN-1]}}, s1_q.a};
  end

  logic [FLEN-1:0] res_fp, pick;
  logic [XLEN-1:0] res_int;
  logic            res_to_int, res_nv;

  always_comb begin
    res_fp     = '0;
    res_int    = '0;
    res_to_int = 1'b0;
    res_nv     = 1'b0;
    pick       = '0;
    if (s1_valid) begin
      case (s1_q.op)
        OP_SGNJN: res_fp = {~b_s, a_mag};
        OP_SGNJX: res_fp = {a_s ^ b_s, a_mag};
        OP_MIN, OP_MAX: begin
          res_nv = any_snan;
          if (s1_q.op == OP_MIN)
            pick = ord_lt ? s1_q.a : s1_q.b;
          else
            pick = ord_lt ? s1_q.b : s1_q.a;
          if (a_nan && b_nan) res_fp = CANON;
          else if (a_nan)     res_fp = s1_q.b;
          else if (b_nan)     res_fp = s1_q.a;
          else                res_fp = pick;
        end
        OP_FEQ: begin
          res_to_int = 1'b1;
          res_nv     = any_snan;
          res_int    = XLEN'(!any_nan && (same || both_zero));
        end
        OP_FLT: begin
          res_to_int = 1'b1;
          res_nv     = any_nan;
          res_int    = XLEN'(!any_nan && ord_lt && !both_zero);
        end
        OP_FLE: begin
          res_to_int = 1'b1;
          res_nv     = any_nan;
          res_int    = XLEN'(!any_nan &&
                             (ord_lt || same || both_zero));
        end
        OP_CLASS: begin
          res_to_int = 1'b1;
          res_int    = XLEN'(s1_q.ca.cls);
        end
        OP_MV_X: begin
          res_to_int = 1'b1;
          res_int    = mvx;
        end
        default: res_fp = {b_s, a_mag};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_fp     <= '0;
      out_int    <= '0;
      out_to_int <= 1'b0;
      out_nv     <= 1'b0;
      out_id     <= '0;
    end else if (s2_free) begin
      out_valid  <= s1_valid;
      out_fp     <= res_fp;
      out_int    <= res_int;
      out_to_int <= res_to_int;
      out_nv     <= res_nv;
      out_id     <= s1_valid ? s1_q.id : '0;
    end
  end

  // A new NV event wins over a same-cycle CSR clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_nv <= 1'b0;
    end else if (out_valid && out_ready && out_nv) begin
      fflags_nv <= 1'b1;
    end else if (fflags_nv_clear) begin
      fflags_nv <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_misc_unit.sv
// Scoreboard bench for fp_misc_unit (single precision) plus a
// double-precision instance for the wide-format cases.
module tb_fp_misc_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_id;
  logic        out_valid, out_ready;
  logic [31:0] out_fp, out_int;
  logic        out_to_int, out_nv;
  logic [4:0]  out_id;
  logic        fflags_nv, fflags_nv_clear;

  logic        d_in_valid, d_in_ready;
  logic [3:0]  d_in_op;
  logic [63:0] d_in_a, d_in_b;
  logic [4:0]  d_in_id;
  logic        d_out_valid, d_out_ready;
  logic [63:0] d_out_fp;
  logic [31:0] d_out_int;
  logic        d_out_to_int, d_out_nv;
  logic [4:0]  d_out_id;
  logic        d_fflags_nv, d_fflags_nv_clear;

  fp_misc_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp(out_fp), .out_int(out_int),
    .out_to_int(out_to_int), .out_nv(out_nv), .out_id(out_id),
    .fflags_nv(fflags_nv), .fflags_nv_clear(fflags_nv_clear)
  );

  fp_misc_unit #(
    .EXP_WIDTH(11), .MANT_WIDTH(52), .XLEN(32), .ID_WIDTH(5)
  ) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_op(d_in_op), .in_a(d_in_a), .in_b(d_in_b),
    .in_id(d_in_id),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_fp(d_out_fp), .out_int(d_out_int),
    .out_to_int(d_out_to_int), .out_nv(d_out_nv),
    .out_id(d_out_id),
    .fflags_nv(d_fflags_nv),
    .fflags_nv_clear(d_fflags_nv_clear)
  );

  typedef struct {
    logic [31:0] fp;
    logic [31:0] ival;
    logic        to_int;
    logic        nv;
    logic [4:0]  id;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, want);
    end
  endtask

  function automatic exp_t ef(logic [31:0] fp, logic nv,
                              logic [4:0] id);
    exp_t e;
    e = '{fp: fp, ival: 32'd0, to_int: 1'b0, nv: nv,
          id: id, acc: 0, lat: 1'b0};
    return e;
  endfunction

  function automatic exp_t ei(logic [31:0] iv, logic nv,
                              logic [4:0] id);
    exp_t e;
    e = '{fp: 32'd0, ival: iv, to_int: 1'b1, nv: nv,
          id: id, acc: 0, lat: 1'b0};
    return e;
  endfunction

  // Order-preserving key: unsigned compare of keys is FP order.
  function automatic logic [31:0] key(logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic exp_t model(logic [3:0] op, logic [31:0] a,
                                 logic [31:0] b, logic [4:0] id);
    logic na, nb, sa, sb_, bz, lt;
    logic [22:0] m;
    int bitn;
    na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sa  = na && !a[22];
    sb_ = nb && !b[22];
    bz  = (a[30:0] == 0) && (b[30:0] == 0);
    lt  = key(a) < key(b);
    case (op)
      4'd1: return ef({~b[31], a[30:0]}, 0, id);
      4'd2: return ef({a[31] ^ b[31], a[30:0]}, 0, id);
      4'd3, 4'd4: begin
        if (na && nb) return ef(32'h7FC0_0000, sa | sb_, id);
        if (na) return ef(b, sa | sb_, id);
        if (nb) return ef(a, sa | sb_, id);
        if (op == 4'd3) return ef(lt ? a : b, 0, id);
        return ef(lt ? b : a, 0, id);
      end
      4'd5: return ei(32'(!(na || nb) && (a == b || bz)),
                      sa | sb_, id);
      4'd6: return ei(32'(!(na || nb) && lt && !bz),
                      na | nb, id);
      4'd7: return ei(32'(!(na || nb) && (lt || a == b || bz)),
                      na | nb, id);
      4'd8: begin
        m = a[22:0];
        if (a[30:23] == 8'hFF)
          bitn = (m == 0) ? (a[31] ? 0 : 7) : (m[22] ? 9 : 8);
        else if (a[30:23] == 0)
          bitn = (m == 0) ? (a[31] ? 3 : 4) : (a[31] ? 2 : 5);
        else
          bitn = a[31] ? 1 : 6;
        return ei(32'd1 << bitn, 0, id);
      end
      4'd9: return ei(a, 0, id);
      default: return ef({b[31], a[30:0]}, 0, id);
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #3;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: backpressure model, hold-stability, scoreboard pop.
  logic        hold_pend = 0;
  logic [31:0] h_fp, h_int;
  logic [4:0]  h_id;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      hold_pend = 0;
    end else begin
      check("in_ready", in_ready,
            !(sb.size() >= 2 && !out_ready));
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_fp", out_fp, h_fp);
        check("hold_int", out_int, h_int);
        check("hold_id", out_id, h_id);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("out_fp", out_fp, e.fp);
          check("out_int", out_int, e.ival);
          check("out_to_int", out_to_int, e.to_int);
          check("out_nv", out_nv, e.nv);
          check("out_id", out_id, e.id);
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      hold_pend = out_valid && !out_ready;
      h_fp  = out_fp;
      h_int = out_int;
      h_id  = out_id;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] id,
                      input exp_t e, input bit lat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b; in_id = id;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1);
    e.acc = cyc;
    e.lat = lat;
    @(posedge clk);
    if (n < 100) sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v, input bit rnd);
    @(posedge clk);
    #2;
    rand_rdy  = rnd;
    out_ready = v;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic send_d(input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] fp, input logic [31:0] iv,
                        input logic to_int, input logic nv);
    int n;
    n = 0;
    @(negedge clk);
    d_in_valid = 1'b1;
    d_in_op = op; d_in_a = a; d_in_b = b; d_in_id = 5'd3;
    while (!d_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("d_accept", d_in_ready, 1);
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    n = 0;
    while (!d_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("d_valid", d_out_valid, 1);
    check("d_fp", d_out_fp, fp);
    check("d_int", d_out_int, iv);
    check("d_to_int", d_out_to_int, to_int);
    check("d_nv", d_out_nv, nv);
    check("d_id", d_out_id, 5'd3);
  endtask

  logic [31:0] vals [12] = '{
    32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
    32'h0000_0001, 32'h807F_FFFF, 32'h4000_0000, 32'hC000_0000
  };

  initial begin
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_id = 0;
    out_ready = 1; fflags_nv_clear = 0;
    d_in_valid = 0; d_in_op = 0; d_in_a = 0; d_in_b = 0;
    d_in_id = 0; d_out_ready = 1; d_fflags_nv_clear = 0;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fp", out_fp, 0);
    check("rst_out_int", out_int, 0);
    check("rst_fflags", fflags_nv, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    send(4'd1, 32'h3F80_0000, 32'h3F80_0000, 5'd1,
         ef(32'hBF80_0000, 0, 5'd1), 1);
    send(4'd3, 32'h7F80_0001, 32'h4000_0000, 5'd2,
         ef(32'h4000_0000, 1, 5'd2), 1);
    wait_out("min_snan_valid");
    while (out_id != 5'd2 && out_valid) @(negedge clk);
    check("nv_pre", fflags_nv, 0);
    @(negedge clk);
    check("nv_post", fflags_nv, 1);
    wait_drain();

    set_ready(0, 0);
    send(4'd0, 32'h3F80_0000, 32'h0, 5'd7, ef(32'h3F80_0000, 0, 5'd7), 0);
    send(4'd0, 32'h4000_0000, 32'h0, 5'd8, ef(32'h4000_0000, 0, 5'd8), 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_fp", out_fp, 0);
    check("mid_rst_id", out_id, 0);
    check("mid_rst_fflags", fflags_nv, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    set_ready(1, 0);
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_valid", out_valid, 0);

    send(4'd3, 32'h7F80_0001, 32'h3F80_0000, 5'd9,
         ef(32'h3F80_0000, 1, 5'd9), 0);
    wait_out("clr_valid");
    fflags_nv_clear = 1'b1;
    @(negedge clk);
    check("nv_set_wins", fflags_nv, 1);
    @(negedge clk);
    check("nv_clear", fflags_nv, 0);
    fflags_nv_clear = 1'b0;

    send(4'd4, 32'h8000_0000, 32'h0000_0000, 5'd10,
         ef(32'h0000_0000, 0, 5'd10), 0);
    send(4'd6, 32'h7FC0_0000, 32'h0, 5'd11, ei(32'd0, 1, 5'd11), 0);
    send(4'd5, 32'h7FC0_0000, 32'h0, 5'd12, ei(32'd0, 0, 5'd12), 0);
    send(4'd7, 32'h8000_0000, 32'h0, 5'd13, ei(32'd1, 0, 5'd13), 0);
    send(4'd8, 32'h0000_0001, 32'h0, 5'd14, ei(32'h20, 0, 5'd14), 0);
    send(4'd8, 32'hFF80_0000, 32'h0, 5'd15, ei(32'h1, 0, 5'd15), 0);
    send(4'd9, 32'hBF80_0000, 32'h0, 5'd16,
         ei(32'hBF80_0000, 0, 5'd16), 0);
    send(4'd13, 32'h3F80_0000, 32'h8000_0000, 5'd17,
         ef(32'hBF80_0000, 0, 5'd17), 0);
    wait_drain();

    set_ready(1, 1);
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = vals[$urandom_range(0, 11)];
      b  = vals[$urandom_range(0, 11)];
      send(op, a, b, 5'(i), model(op, a, b, 5'(i)), 0);
    end
    wait_drain();
    set_ready(1, 0);

    send_d(4'd9, 64'hC000_0000_1234_5678, 64'h0,
           64'h0, 32'h1234_5678, 1, 0);
    send_d(4'd3, 64'h7FF8_0000_0000_0000, 64'hFFF8_0000_0000_0001,
           64'h7FF8_0000_0000_0000, 32'h0, 0, 0);
    send_d(4'd4, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
           64'h3FF0_0000_0000_0000, 32'h0, 0, 1);
    send_d(4'd8, 64'h0000_0000_0000_0001, 64'h0,
           64'h0, 32'h20, 1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at limit");
    $fatal(1);
  end

endmodule
